// File: rtl/ct_spsram_1024x92_ctrl_pkg.sv
// Shared definitions for the 1024x92 single-port SRAM controller:
// FSM encoding, default geometry and the last address of the clear sweep.
package ct_spsram_1024x92_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 92;
    localparam int INIT_LAST_ADDR = 1023;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// In-order read-response buffer for the SRAM controller; the caller
// guarantees it never pushes when full or pops when empty.
module ct_spsram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 92,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the data array is deliberately not reset; an entry is only ever
    // read after it was pushed, and the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/ct_spsram_1024x92_ctrl.sv
// Request/response front end for a 1024x92 single-port SRAM: clears the
// array after reset or on demand, then serves credit-gated reads and writes.
module ct_spsram_1024x92_ctrl
    import ct_spsram_1024x92_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    // request port
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    // response port
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    // init port
    input  logic                  init_start,
    output logic                  init_busy,
    // SRAM port
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0] RSP_DEPTH_L = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_LAST_ADDR);

    ctrl_state_e           state;
    ctrl_state_e           state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] init_cnt_nxt;
    logic                  rd_inflight;
    logic                  rd_accept;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credits_used;

    // A read occupies a credit from acceptance until its response is popped.
    assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight};
    assign rd_accept    = req_vld & req_rdy & ~req_wr;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            rd_inflight <= rd_accept;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        req_rdy      = 1'b0;
        init_busy    = 1'b0;
        sram_a       = '0;
        sram_cen     = 1'b1;
        sram_gwen    = 1'b1;
        sram_wen     = '1;
        sram_d       = '0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                // Keep the macro deselected while reset is held.
                if (cpurst_b) begin
                    sram_a    = init_cnt;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                end
                if (init_cnt == LAST_ADDR) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                req_rdy = (credits_used < RSP_DEPTH_L);
                if (req_vld && req_rdy) begin
                    sram_a    = req_addr;
                    sram_cen  = 1'b0;
                    sram_gwen = ~req_wr;
                    sram_wen  = req_wr ? ~req_wmask : '1;
                    sram_d    = req_wdata;
                end
                if (init_start) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    ct_spsram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .push      (rd_inflight),
        .push_data (sram_q),
        .pop       (rsp_vld & rsp_rdy),
        .pop_data  (rsp_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_vld = ~fifo_empty;

endmodule

// File: tb/tb_ct_spsram_1024x92_ctrl.sv
// Self-checking bench for ct_spsram_1024x92_ctrl: a behavioural SRAM plus a
// transaction-level reference (memory image and pending-response queue).
module tb_ct_spsram_1024x92_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 92;
    localparam int DEPTH = 3;
    localparam int WORDS = 1024;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_start;
    logic          init_busy;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_spsram_1024x92_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_start     (init_start),
        .init_busy      (init_busy),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural SRAM macro: bit-masked write, registered read.
    logic [DW-1:0] sram_mem [WORDS];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    // Reference model: memory image, clear countdown and pending read responses.
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } rsp_t;

    logic [DW-1:0] ref_mem [WORDS];
    rsp_t          pend_q[$];
    int            init_left;
    int unsigned   cyc;
    bit            last_accept;
    logic          dut_accept;
    int            n_vec;
    int            n_err;

    function automatic logic [DW-1:0] rand_dw();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model.
    task automatic step();
        bit            exp_rdy;
        bit            exp_vld;
        bit            acc;
        bit            pop;
        int            a;
        @(negedge forever_cpuclk);
        exp_rdy = (init_left == 0) && (pend_q.size() < DEPTH);
        exp_vld = (pend_q.size() > 0) && (cyc >= pend_q[0].due);
        acc     = req_vld && exp_rdy;
        pop     = exp_vld && rsp_rdy;
        dut_accept = req_vld & req_rdy;
        check("init_busy", DW'(init_busy), DW'(init_left > 0));
        check("req_rdy", DW'(req_rdy), DW'(exp_rdy));
        check("rsp_vld", DW'(rsp_vld), DW'(exp_vld));
        if (exp_vld) check("rsp_rdata", rsp_rdata, pend_q[0].data);
        if (init_left > 0) begin
            check("init_cen", DW'(sram_cen), '0);
            check("init_gwen", DW'(sram_gwen), '0);
            check("init_a", DW'(sram_a), DW'(WORDS - init_left));
            check("init_wen", sram_wen, '0);
            check("init_d", sram_d, '0);
        end else if (acc) begin
            check("acc_cen", DW'(sram_cen), '0);
            check("acc_a", DW'(sram_a), DW'(req_addr));
            check("acc_gwen", DW'(sram_gwen), DW'(!req_wr));
            check("acc_wen", sram_wen, req_wr ? ~req_wmask : '1);
            check("acc_d", sram_d, req_wdata);
        end else begin
            check("idle_cen", DW'(sram_cen), DW'(1));
            check("idle_gwen", DW'(sram_gwen), DW'(1));
        end
        @(posedge forever_cpuclk);
        a = int'(req_addr);
        if (acc) begin
            if (req_wr) ref_mem[a] = (ref_mem[a] & ~req_wmask) | (req_wdata & req_wmask);
            else        pend_q.push_back('{data: ref_mem[a], due: cyc + 2});
        end
        if (pop) void'(pend_q.pop_front());
        if (init_left > 0) begin
            ref_mem[WORDS - init_left] = '0;
            init_left--;
        end else if (init_start) begin
            init_left = WORDS;
        end
        cyc++;
        last_accept = acc;
        #1;
    endtask

    task automatic idle(input int n);
        req_vld = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a request until accepted; an expired budget is a failed comparison.
    task automatic issue(input bit wr, input int addr, input logic [DW-1:0] data,
                         input logic [DW-1:0] mask, input int budget);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = AW'(addr);
        req_wdata = data;
        req_wmask = mask;
        for (int i = 0; i < budget; i++) begin
            step();
            if (last_accept) break;
        end
        check("issue_accepted", DW'(dut_accept), DW'(1));
        req_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"}, DW'(sram_cen), DW'(1));
        check({tag, "_busy"}, DW'(init_busy), DW'(1));
        check({tag, "_rdy"}, DW'(req_rdy), '0);
        check({tag, "_vld"}, DW'(rsp_vld), '0);
    endtask

    task automatic apply_reset();
        #2 cpurst_b = 1'b0;
        #1;
        check_reset_outputs("midrst");
        pend_q.delete();
        init_left = WORDS;
        @(posedge forever_cpuclk);
        @(posedge forever_cpuclk);
        #1 cpurst_b = 1'b1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        init_left  = WORDS;
        cpurst_b   = 1'b0;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        rsp_rdy    = 1'b1;
        init_start = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = rand_dw();
            ref_mem[i]  = '0;
        end

        // Reset state, then the full clear sweep and first ready cycle.
        repeat (2) @(posedge forever_cpuclk);
        #1;
        check_reset_outputs("rst");
        @(posedge forever_cpuclk);
        #1 cpurst_b = 1'b1;
        idle(WORDS + 2);

        // Full-mask write then read back with 2-cycle latency.
        issue(1'b1, 5, DW'(92'h3FF), '1, 2);
        issue(1'b0, 5, '0, '0, 2);
        idle(4);

        // Partial-mask write into a cleared entry.
        issue(1'b1, 7, '1, DW'(92'hFF), 2);
        issue(1'b0, 7, '0, '0, 2);
        idle(4);

        // Credit back-pressure with the consumer stalled.
        for (int k = 1; k <= 4; k++) issue(1'b1, k, DW'(k), '1, 2);
        rsp_rdy = 1'b0;
        for (int k = 1; k <= 3; k++) issue(1'b0, k, '0, '0, 1);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = AW'(4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd4_blocked", DW'(dut_accept), '0);
        end
        rsp_rdy = 1'b1;
        issue(1'b0, 4, '0, '0, 4);
        idle(5);

        // Back-to-back streaming reads must be accepted every cycle.
        for (int k = 0; k < 16; k++) issue(1'b0, k, '0, '0, 1);
        idle(4);

        // Random mixed traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            req_vld   = ($urandom_range(0, 3) != 0);
            req_wr    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = rand_dw();
            req_wmask = rand_dw();
            rsp_rdy   = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_rdy = 1'b1;
        idle(6);

        // Clear requested alongside a read; a repeat request mid-clear is ignored.
        init_start = 1'b1;
        issue(1'b0, 5, '0, '0, 1);
        init_start = 1'b0;
        idle(300);
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        idle(WORDS);
        issue(1'b0, 5, '0, '0, 2);
        issue(1'b0, 7, '0, '0, 2);
        issue(1'b0, 1, '0, '0, 2);
        idle(4);

        // Reset with buffered and in-flight reads discards them.
        issue(1'b1, 9, rand_dw(), '1, 2);
        rsp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) issue(1'b0, 9, '0, '0, 1);
        apply_reset();
        rsp_rdy = 1'b1;
        idle(WORDS + 2);
        issue(1'b0, 9, '0, '0, 2);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ct_spsram_1024x92_ctrl.md
CT_SPSRAM_1024X92_CTRL -- requirements
Module: ct_spsram_1024x92_ctrl

Interface
REQ-001 SHALL provide parameters: ADDR_WIDTH, default 10, SRAM address width; DATA_WIDTH, default 92, data width; RSP_DEPTH, default 3, number of entries in the read-response FIFO.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: forever_cpuclk  input  1  sole clock; cpurst_b  input  1  asynchronous active-low reset.
REQ-003 SHALL provide the request port:
- req_vld  input  1  request valid.
- req_rdy  output  1  request accepted when high together with req_vld.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  10  entry address.
- req_wdata  input  92  write data.
- req_wmask  input  92  per-bit write enable, active-high.
REQ-004 SHALL provide the response port: rsp_vld  output  1  read data valid; rsp_rdy  input  1  consumer ready; rsp_rdata  output  92  read data.
REQ-005 SHALL provide the init port: init_start  input  1  pulse requesting a full-memory clear; init_busy  output  1  clear in progress.
REQ-006 SHALL provide the SRAM-side port:
- sram_a  output  10  address.
- sram_cen  output  1  chip enable, active-low.
- sram_gwen  output  1  global write enable, active-low.
- sram_wen  output  92  bit write enable, active-low.
- sram_d  output  92  write data.
- sram_q  input  92  read data, valid one cycle after a read access.

Function
REQ-007 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-008 In INIT, SHALL write zero to one entry per cycle: counter 0..1023, sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0; after entry 1023, SHALL enter RUN the next cycle (1024 cycles total); no wrap beyond 1023.
REQ-009 init_busy SHALL be 1 exactly while state is INIT.
REQ-010 In RUN, SHALL assert req_rdy when (FIFO occupancy + read-in-flight flag) < RSP_DEPTH; SHALL hold req_rdy at 0 in INIT.
REQ-011 An accepted request SHALL drive the SRAM combinationally in the same cycle:
- sram_a=req_addr, sram_cen=0, sram_gwen=req_wr ? 0 : 1.
- sram_wen=~req_wmask for writes, all 1 for reads.
- sram_d=req_wdata.
REQ-012 With no access, SHALL drive sram_cen=1, sram_gwen=1, sram_wen all 1, sram_a=0, sram_d=0.
REQ-013 Writes SHALL produce no response.
REQ-014 An accepted read SHALL set a registered in-flight flag; in the following cycle, sram_q SHALL be pushed into the FIFO.
- Minimum read latency from acceptance to rsp_vld is 2 cycles.
REQ-015 The FIFO SHALL be in-order; rsp_vld = FIFO not empty; rsp_rdata = head entry.
- Pop on rsp_vld & rsp_rdy.
- Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-016 With rsp_rdy held at 1, SHALL sustain one read per cycle.
REQ-017 The FIFO can never overflow by construction; credit gating (REQ-010) is the only back-pressure.
REQ-018 init_start sampled in RUN SHALL enter INIT the next cycle.
- A request accepted in that same cycle completes normally.
- An outstanding read in flight still lands in the FIFO.
- The FIFO keeps draining during INIT.
REQ-019 init_start while in INIT SHALL be ignored; the counter is not restarted.

Reset
REQ-020 On cpurst_b low, SHALL asynchronously set:
- state=INIT, counter=0, in-flight flag=0, FIFO empty.
- rsp_vld=0, req_rdy=0, init_busy=1.
REQ-021 Reset mid-operation SHALL discard buffered and in-flight reads and restart the clear from entry 0.
REQ-022 SRAM outputs SHALL follow REQ-008 from the first cycle after reset release; while reset is asserted, sram_cen SHALL be 1.

Structure
REQ-023 SHALL place the FSM state encoding, ADDR_WIDTH/DATA_WIDTH defaults and the final init address (1023) in a shared package.
REQ-024 SHALL implement the response FIFO as one sub-module, ct_spsram_rsp_fifo (parameterised depth and width, synchronous push/pop, asynchronous active-low reset).
REQ-025 SHALL connect to ct_spsram_1024x92 directly, with no glue logic.

Verification
REQ-026 Reset release -> init_busy=1 for exactly 1024 cycles, sram_gwen=0 each cycle with sram_a stepping 0..1023, then req_rdy=1.
REQ-027 Write addr 5, data 0x3FF, mask all 1; then read addr 5 -> rsp_rdata=0x3FF, rsp_vld 2 cycles after read acceptance.
REQ-028 Masked write with low 8 mask bits set, data all 1, to a zeroed entry; read back -> 0xFF.
REQ-029 rsp_rdy=0, issue reads to addr 1,2,3,4 -> exactly 3 accepted and req_rdy=0; then rsp_rdy=1 -> data 1,2,3 in order, 4th read accepted.
REQ-030 Streaming reads with rsp_rdy=1 -> one acceptance per cycle, no bubbles.
REQ-031 init_start coinciding with an accepted read -> read response delivered, then 1024-cycle clear; previously written entries read 0.
